vfpu_stream_ctrl_fsm: RTL and testbench

- Sequencing controller between the VFPU control register file and the hwpe-stream source/sink streamers.
- Snapshots the 14 control registers (operand A, operand B, result, transaction size, operation select) on a start trigger and unpacks them into per-streamer address-generator configs.
- Fires the streamer start requests, counts result beats, and collects streamer done flags.
- Pulses done_o to the event unit when the job completes.

---
 rtl/vfpu_stream_ctrl_fsm.sv | 148 ++++++++++++++
 tb/tb_vfpu_stream_ctrl_fsm.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfpu_stream_ctrl_fsm.sv
// VFPU stream sequencer: snapshots control registers, kicks the three streamers,
// and signals job completion. Optional busy-cycle counter via VFPU_CTRL_PERF_CNT_EN.
module vfpu_stream_ctrl_fsm #(
   parameter int NB_REGS = 14,
   parameter int OP_W    = 4,
   parameter int CNT_W   = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   start_i,
   input  logic [NB_REGS*32-1:0]  regs_i,
   output logic                   src_a_req_o,
   output logic                   src_b_req_o,
   output logic                   sink_req_o,
   output logic [159:0]           src_a_cfg_o,
   output logic [159:0]           src_b_cfg_o,
   output logic [159:0]           sink_cfg_o,
   output logic [OP_W-1:0]        op_sel_o,
   input  logic                   src_a_done_i,
   input  logic                   src_b_done_i,
   input  logic                   sink_done_i,
   input  logic                   out_beat_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o
`ifdef VFPU_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]            perf_cnt_o
`endif
);

   // state    | meaning
   // IDLE     | waiting for start_i; snapshot taken on accepted start
   // ISSUE    | one-cycle start pulse to all three streamers
   // RUN      | collecting result beats and streamer done flags
   // DONE     | one-cycle completion event to the event unit
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RUN, ST_DONE} state_t;

   localparam int TS_REG = 12;
   localparam int OP_REG = 13;

   state_t state_q, state_d;

   logic [CNT_W-1:0] trans_q, beat_cnt_q, beat_cnt_d, reg_ts;
   logic [2:0]       done_q, done_d, done_in;
   logic             start_acc, active, beat_at_max, beat_inc, err_set;
   logic             unused_reg_bits;

   // Register fields are 16-bit pairs packed high/low; the config bus wants them low/high.
   function automatic logic [159:0] pack_cfg(input logic [31:0] base, input logic [31:0] line,
                                             input logic [31:0] feat, input logic [31:0] loops,
                                             input logic [31:0] ts);
      return {loops[15:0], loops[31:16], feat[15:0], feat[31:16],
              line[15:0], line[31:16], ts, base};
   endfunction

   assign reg_ts          = regs_i[TS_REG*32 +: CNT_W];
   assign unused_reg_bits = ^regs_i[OP_REG*32+OP_W +: 32-OP_W];

   assign start_acc   = (state_q == ST_IDLE) && start_i;
   assign active      = (state_q == ST_ISSUE) || (state_q == ST_RUN);
   assign done_in     = {sink_done_i, src_b_done_i, src_a_done_i};
   assign done_d      = done_q | (done_in & {3{active}});
   assign beat_at_max = (beat_cnt_q == trans_q);
   assign beat_inc    = active && out_beat_i && !beat_at_max;
   assign err_set     = active && out_beat_i && beat_at_max;
   assign beat_cnt_d  = beat_cnt_q + {{(CNT_W-1){1'b0}}, beat_inc};

   always_comb begin
      state_d     = state_q;
      src_a_req_o = 1'b0;
      src_b_req_o = 1'b0;
      sink_req_o  = 1'b0;
      done_o      = 1'b0;
      busy_o      = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i) state_d = (reg_ts == '0) ? ST_DONE : ST_ISSUE;
         end
         ST_ISSUE: begin
            src_a_req_o = 1'b1;
            src_b_req_o = 1'b1;
            sink_req_o  = 1'b1;
            state_d     = ST_RUN;
         end
         // Decide on this cycle's updated flags/count so completion costs one cycle.
         ST_RUN: if ((&done_d) && (beat_cnt_d == trans_q)) state_d = ST_DONE;
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         trans_q     <= '0;
         beat_cnt_q  <= '0;
         done_q      <= '0;
         err_o       <= 1'b0;
         src_a_cfg_o <= '0;
         src_b_cfg_o <= '0;
         sink_cfg_o  <= '0;
         op_sel_o    <= '0;
      end else if (clear_i) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         done_q     <= '0;
         err_o      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            trans_q     <= reg_ts;
            beat_cnt_q  <= '0;
            done_q      <= '0;
            err_o       <= 1'b0;
            src_a_cfg_o <= pack_cfg(regs_i[0*32 +: 32], regs_i[1*32 +: 32], regs_i[2*32 +: 32],
                                    regs_i[3*32 +: 32], regs_i[TS_REG*32 +: 32]);
            src_b_cfg_o <= pack_cfg(regs_i[4*32 +: 32], regs_i[5*32 +: 32], regs_i[6*32 +: 32],
                                    regs_i[7*32 +: 32], regs_i[TS_REG*32 +: 32]);
            sink_cfg_o  <= pack_cfg(regs_i[8*32 +: 32], regs_i[9*32 +: 32], regs_i[10*32 +: 32],
                                    regs_i[11*32 +: 32], regs_i[TS_REG*32 +: 32]);
            op_sel_o    <= regs_i[OP_REG*32 +: OP_W];
         end else begin
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
            if (err_set) err_o <= 1'b1;
         end
      end
   end

`ifdef VFPU_CTRL_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                  perf_q <= '0;
      else if (clear_i || start_acc)                perf_q <= '0;
      else if (state_q != ST_IDLE && perf_q != '1)  perf_q <= perf_q + 32'd1;
   end

   assign perf_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_vfpu_stream_ctrl_fsm.sv
// Self-checking bench for vfpu_stream_ctrl_fsm; checks perf_cnt_o when
// VFPU_CTRL_PERF_CNT_EN is defined.
module tb_vfpu_stream_ctrl_fsm;
   localparam int MAXC = 64;

   logic          clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
   logic [447:0]  regs_i;
   logic          src_a_req_o, src_b_req_o, sink_req_o;
   logic [159:0]  src_a_cfg_o, src_b_cfg_o, sink_cfg_o;
   logic [3:0]    op_sel_o;
   logic          src_a_done_i = 1'b0, src_b_done_i = 1'b0, sink_done_i = 1'b0, out_beat_i = 1'b0;
   logic          busy_o, done_o, err_o;
   logic [31:0]   perf_cnt_o;

   vfpu_stream_ctrl_fsm dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .regs_i(regs_i),
      .src_a_req_o(src_a_req_o), .src_b_req_o(src_b_req_o), .sink_req_o(sink_req_o),
      .src_a_cfg_o(src_a_cfg_o), .src_b_cfg_o(src_b_cfg_o), .sink_cfg_o(sink_cfg_o),
      .op_sel_o(op_sel_o), .src_a_done_i(src_a_done_i), .src_b_done_i(src_b_done_i),
      .sink_done_i(sink_done_i), .out_beat_i(out_beat_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o)
`ifdef VFPU_CTRL_PERF_CNT_EN
      , .perf_cnt_o(perf_cnt_o)
`endif
   );

`ifndef VFPU_CTRL_PERF_CNT_EN
   assign perf_cnt_o = '0;
`endif

   always #5 clk_i = ~clk_i;

   logic [31:0] r  [14];
   logic [31:0] er [14];
   always_comb begin
      regs_i = '0;
      for (int k = 0; k < 14; k++) regs_i[32*k +: 32] = r[k];
   end

   int errors = 0, checks = 0;
   bit sb[MAXC], sda[MAXC], sdb[MAXC], sds[MAXC], sst[MAXC], scl[MAXC];
   int srw;
   int o_dn, o_dc, o_ra, o_rb, o_rs, o_rc, o_busy;
   logic o_err_c1, o_err_end;
   logic [31:0] o_perf;

   task automatic clear_sched();
      for (int k = 0; k < MAXC; k++) begin
         sb[k] = 0; sda[k] = 0; sdb[k] = 0; sds[k] = 0; sst[k] = 0; scl[k] = 0;
      end
      srw = -1;
   endtask

   task automatic rand_regs(input logic [31:0] ts);
      for (int k = 0; k < 14; k++) r[k] = $urandom;
      r[12] = ts;
   endtask

   // Expected config derived from the register snapshot, field by field.
   function automatic logic [159:0] exp_cfg(input int g);
      logic [159:0] c;
      c[31:0]    = er[4*g];
      c[63:32]   = er[12];
      c[79:64]   = er[4*g+1][31:16];
      c[95:80]   = er[4*g+1][15:0];
      c[111:96]  = er[4*g+2][31:16];
      c[127:112] = er[4*g+2][15:0];
      c[143:128] = er[4*g+3][31:16];
      c[159:144] = er[4*g+3][15:0];
      return c;
   endfunction

   // Reference: replay the schedule as events; job ends the cycle after beats reach
   // the size and every streamer has reported, but never before cycle 3.
   task automatic model_job(input int ts, output int d, output bit e);
      int cnt;
      bit ga, gb, gs;
      cnt = 0; ga = 0; gb = 0; gs = 0; d = -1; e = 0;
      if (ts == 0) begin
         d = 1;
         return;
      end
      for (int k = 1; k < MAXC && d < 0; k++) begin
         if (sb[k] && cnt < ts) cnt++;
         ga |= sda[k]; gb |= sdb[k]; gs |= sds[k];
         if (cnt == ts && ga && gb && gs) d = (k + 1 < 3) ? 3 : k + 1;
      end
      cnt = 0;
      for (int k = 1; k < d; k++)
         if (sb[k]) begin
            if (cnt == ts) e = 1;
            else cnt++;
         end
   endtask

   // Called at a negedge: start in cycle 0, then observe/drive cycles 1..ncyc.
   task automatic run_job(input int ncyc);
      start_i = 1; clear_i = 0; out_beat_i = 0;
      src_a_done_i = 0; src_b_done_i = 0; sink_done_i = 0;
      for (int k = 0; k < 14; k++) er[k] = r[k];
      o_dn = 0; o_dc = -1; o_ra = 0; o_rb = 0; o_rs = 0; o_rc = -1; o_busy = 0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk_i);
         if (k == 1) o_err_c1 = err_o;
         if (done_o) begin o_dn++; o_dc = k; end
         if (src_a_req_o) begin o_ra++; o_rc = k; end
         if (src_b_req_o) o_rb++;
         if (sink_req_o) o_rs++;
         if (busy_o) o_busy++;
         start_i = sst[k]; clear_i = scl[k]; out_beat_i = sb[k];
         src_a_done_i = sda[k]; src_b_done_i = sdb[k]; sink_done_i = sds[k];
         if (k == srw) begin
            for (int j = 0; j < 14; j++) r[j] = $urandom;
            r[0] = 32'h2000;
         end
      end
      @(negedge clk_i);
      o_err_end = err_o;
      o_perf = perf_cnt_o;
      start_i = 0; clear_i = 0; out_beat_i = 0;
      src_a_done_i = 0; src_b_done_i = 0; sink_done_i = 0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 14; k++) r[k] = $urandom;
      rst_ni = 0;
      repeat (3) @(negedge clk_i);
      if ({src_a_req_o, src_b_req_o, sink_req_o, busy_o, done_o, err_o} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b exp=000000",
                            {src_a_req_o, src_b_req_o, sink_req_o, busy_o, done_o, err_o});
      end
      checks++;
      if ({src_a_cfg_o, src_b_cfg_o, sink_cfg_o, op_sel_o} !== '0) begin
         errors++; $display("FAIL reset_cfg got nonzero exp=0");
      end
      checks++;
      if (perf_cnt_o !== 32'd0) begin
         errors++; $display("FAIL reset_perf got=%0d exp=0", perf_cnt_o);
      end
      checks++;
      rst_ni = 1;
      @(negedge clk_i);
      if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle busy got=%b exp=0", busy_o); end
      checks++;
   endtask

   task automatic test_nominal();
      int d; bit e;
      clear_sched(); rand_regs(32'd8);
      r[0] = 32'h1000; r[1] = 32'h0004_0008; r[13] = 32'd3;
      for (int k = 1; k <= 8; k++) sb[k] = 1;
      sda[8] = 1; sdb[8] = 1; sds[8] = 1;
      model_job(8, d, e);
      run_job(d + 4);
      if (o_ra !== 1 || o_rc !== 1 || o_rb !== 1 || o_rs !== 1) begin
         errors++; $display("FAIL nom_req got a=%0d@%0d b=%0d s=%0d exp 1@1", o_ra, o_rc, o_rb, o_rs);
      end
      checks++;
      if (src_a_cfg_o[79:64] !== 16'd4 || src_a_cfg_o[95:80] !== 16'd8 || src_a_cfg_o[31:0] !== 32'h1000) begin
         errors++; $display("FAIL nom_cfg got stride=%0d len=%0d base=%0h exp 4 8 1000",
                            src_a_cfg_o[79:64], src_a_cfg_o[95:80], src_a_cfg_o[31:0]);
      end
      checks++;
      if (op_sel_o !== 4'd3) begin errors++; $display("FAIL nom_op got=%0d exp=3", op_sel_o); end
      checks++;
      if (o_dn !== 1 || o_dc !== 9) begin
         errors++; $display("FAIL nom_done got n=%0d at=%0d exp n=1 at=9", o_dn, o_dc);
      end
      checks++;
      if (o_err_end !== 1'b0) begin errors++; $display("FAIL nom_err got=%b exp=0", o_err_end); end
      checks++;
`ifdef VFPU_CTRL_PERF_CNT_EN
      if (o_perf !== o_busy || o_perf !== 32'(d)) begin
         errors++; $display("FAIL nom_perf got=%0d exp=%0d", o_perf, d);
      end
      checks++;
`endif
   endtask

   task automatic test_zero_size();
      clear_sched(); rand_regs(32'd0);
      run_job(4);
      if (o_ra + o_rb + o_rs !== 0) begin errors++; $display("FAIL zero_req got=%0d exp=0", o_ra + o_rb + o_rs); end
      checks++;
      if (o_dn !== 1 || o_dc !== 1) begin
         errors++; $display("FAIL zero_done got n=%0d at=%0d exp n=1 at=1", o_dn, o_dc);
      end
      checks++;
      if (o_busy !== 1) begin errors++; $display("FAIL zero_busy got=%0d exp=1", o_busy); end
      checks++;
   endtask

   task automatic test_out_of_order();
      clear_sched(); rand_regs(32'd4);
      for (int k = 1; k <= 4; k++) sb[k] = 1;
      sds[5] = 1; sdb[9] = 1; sda[14] = 1;
      run_job(18);
      if (o_dn !== 1 || o_dc !== 15) begin
         errors++; $display("FAIL ooo_done got n=%0d at=%0d exp n=1 at=15", o_dn, o_dc);
      end
      checks++;
   endtask

   task automatic test_overrun();
      clear_sched(); rand_regs(32'd2);
      sb[1] = 1; sb[2] = 1; sb[3] = 1;
      sda[6] = 1; sdb[6] = 1; sds[6] = 1;
      run_job(10);
      if (o_err_end !== 1'b1) begin errors++; $display("FAIL ovr_err got=%b exp=1", o_err_end); end
      checks++;
      if (o_dn !== 1 || o_dc !== 7) begin
         errors++; $display("FAIL ovr_done got n=%0d at=%0d exp n=1 at=7", o_dn, o_dc);
      end
      checks++;
      clear_sched(); rand_regs(32'd1);
      sb[1] = 1; sda[1] = 1; sdb[1] = 1; sds[1] = 1;
      run_job(5);
      if (o_err_c1 !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", o_err_c1); end
      checks++;
      if (o_dc !== 3) begin errors++; $display("FAIL min_latency got=%0d exp=3", o_dc); end
      checks++;
   endtask

   task automatic test_snapshot();
      clear_sched(); rand_regs(32'd3);
      r[0] = 32'h1000;
      for (int k = 1; k <= 3; k++) sb[k] = 1;
      sda[6] = 1; sdb[6] = 1; sds[6] = 1;
      srw = 3; sst[3] = 1;
      run_job(10);
      if (src_a_cfg_o[31:0] !== 32'h1000) begin
         errors++; $display("FAIL snap_base got=%0h exp=1000", src_a_cfg_o[31:0]);
      end
      checks++;
      if (o_ra !== 1 || o_dn !== 1) begin
         errors++; $display("FAIL snap_req got reqs=%0d dones=%0d exp 1 1", o_ra, o_dn);
      end
      checks++;
      if (sink_cfg_o !== exp_cfg(2)) begin
         errors++; $display("FAIL snap_sink got=%0h exp=%0h", sink_cfg_o, exp_cfg(2));
      end
      checks++;
   endtask

   task automatic test_abort();
      clear_sched(); rand_regs(32'd5);
      sb[1] = 1; sb[2] = 1; scl[3] = 1;
      sda[5] = 1; sdb[5] = 1; sds[5] = 1;
      run_job(8);
      if (o_busy !== 3 || o_dn !== 0) begin
         errors++; $display("FAIL abort got busy=%0d dones=%0d exp busy=3 dones=0", o_busy, o_dn);
      end
      checks++;
`ifdef VFPU_CTRL_PERF_CNT_EN
      if (o_perf !== 32'd0) begin errors++; $display("FAIL abort_perf got=%0d exp=0", o_perf); end
      checks++;
`endif
   endtask

   task automatic test_random();
      int d, ts, cnt, ncyc; bit e;
      for (int j = 0; j < 40; j++) begin
         ts = $urandom_range(0, 6);
         clear_sched(); rand_regs(32'(ts));
         cnt = 0;
         for (int k = 1; k <= 16; k++)
            if (cnt < ts && $urandom_range(0, 1) == 1) begin sb[k] = 1; cnt++; end
         for (int k = 17; cnt < ts; k++) begin sb[k] = 1; cnt++; end
         sda[$urandom_range(1, 18)] = 1;
         sdb[$urandom_range(1, 18)] = 1;
         sds[$urandom_range(1, 18)] = 1;
         model_job(ts, d, e);
         if ($urandom_range(0, 1) == 1) srw = $urandom_range(1, 10);
         if ($urandom_range(0, 1) == 1) sst[$urandom_range(1, d)] = 1;
         ncyc = ($urandom_range(0, 1) == 1) ? d : d + $urandom_range(1, 3);
         run_job(ncyc);
         if (o_dn !== 1 || o_dc !== d) begin
            errors++; $display("FAIL rnd%0d_done got n=%0d at=%0d exp n=1 at=%0d", j, o_dn, o_dc, d);
         end
         checks++;
         if (o_ra !== (ts > 0 ? 1 : 0) || o_rb !== o_ra || o_rs !== o_ra || (ts > 0 && o_rc !== 1)) begin
            errors++; $display("FAIL rnd%0d_req got a=%0d b=%0d s=%0d at=%0d exp %0d", j, o_ra, o_rb, o_rs,
                               o_rc, ts > 0 ? 1 : 0);
         end
         checks++;
         if (o_busy !== d) begin errors++; $display("FAIL rnd%0d_busy got=%0d exp=%0d", j, o_busy, d); end
         checks++;
         if (o_err_end !== e) begin errors++; $display("FAIL rnd%0d_err got=%b exp=%b", j, o_err_end, e); end
         checks++;
         if (src_a_cfg_o !== exp_cfg(0) || src_b_cfg_o !== exp_cfg(1) || sink_cfg_o !== exp_cfg(2)) begin
            errors++; $display("FAIL rnd%0d_cfg got a=%0h exp a=%0h", j, src_a_cfg_o, exp_cfg(0));
         end
         checks++;
         if (op_sel_o !== er[13][3:0]) begin
            errors++; $display("FAIL rnd%0d_op got=%0d exp=%0d", j, op_sel_o, er[13][3:0]);
         end
         checks++;
`ifdef VFPU_CTRL_PERF_CNT_EN
         if (o_perf !== 32'(d)) begin errors++; $display("FAIL rnd%0d_perf got=%0d exp=%0d", j, o_perf, d); end
         checks++;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_zero_size();
      test_out_of_order();
      test_overrun();
      test_snapshot();
      test_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
